// File: rtl/frame_fifo_pkg.sv
// Shared constants for the frame FIFO: default geometry, width ratio and
// the almost-full / almost-empty thresholds.
package frame_fifo_pkg;

  localparam int DFLT_WR_DEPTH_WIDTH   = 10;
  localparam int DFLT_WR_DATA_WIDTH    = 128;
  localparam int DFLT_RD_DEPTH_WIDTH   = 13;
  localparam int DFLT_RD_DATA_WIDTH    = 16;

  // Read words per write word and its log2
  localparam int RATIO                 = DFLT_WR_DATA_WIDTH / DFLT_RD_DATA_WIDTH;
  localparam int RATIO_LOG2            = DFLT_RD_DEPTH_WIDTH - DFLT_WR_DEPTH_WIDTH;

  localparam int DFLT_ALMOST_FULL_NUM  = 960;
  localparam int DFLT_ALMOST_EMPTY_NUM = 512;

endpackage

// File: rtl/frame_fifo_ram.sv
// Simple dual-port RAM with a synchronous read port. A write and a read of
// the same address on one edge return the newly written word, so the FIFO
// can hand out a slot the cycle after it was filled.
module frame_fifo_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port plus registered read with write-through on address match
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      q <= wdata;
    end else begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_fifo_w2n.sv
// Single-clock wide-to-narrow FIFO: 128-bit writes, 16-bit reads, least
// significant slice first. Occupancy is tracked in read words; all flags
// are registered from the next-state count.
// Optional macro FIFO_WATER_LEVEL_EN adds wr_water_level / rd_water_level.
module frame_fifo_w2n
  import frame_fifo_pkg::*;
#(
  parameter int WR_DEPTH_WIDTH   = DFLT_WR_DEPTH_WIDTH,
  parameter int WR_DATA_WIDTH    = DFLT_WR_DATA_WIDTH,
  parameter int RD_DEPTH_WIDTH   = DFLT_RD_DEPTH_WIDTH,
  parameter int RD_DATA_WIDTH    = DFLT_RD_DATA_WIDTH,
  parameter int ALMOST_FULL_NUM  = DFLT_ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = DFLT_ALMOST_EMPTY_NUM
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_empty,
  output logic                     almost_empty
`ifdef FIFO_WATER_LEVEL_EN
  ,
  output logic [WR_DEPTH_WIDTH:0]  wr_water_level,
  output logic [RD_DEPTH_WIDTH:0]  rd_water_level
`endif
);

  localparam int SLICES  = WR_DATA_WIDTH / RD_DATA_WIDTH;
  localparam int SLICE_W = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
  localparam int CNT_W   = RD_DEPTH_WIDTH + 1;

  localparam logic [CNT_W-1:0] INC      = CNT_W'(SLICES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_THR = CNT_W'((1 << RD_DEPTH_WIDTH) - SLICES);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(ALMOST_FULL_NUM);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(ALMOST_EMPTY_NUM);

  // Write-side level: read-word count rounded up to whole write words
  function automatic logic [CNT_W-1:0] ceil_words(input logic [CNT_W-1:0] c);
    return (c + CNT_W'(SLICES - 1)) >> SLICE_W;
  endfunction

  logic [WR_DEPTH_WIDTH-1:0] wr_ptr;
  logic [RD_DEPTH_WIDTH-1:0] rd_ptr;
  logic [RD_DEPTH_WIDTH-1:0] rd_ptr_next;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          cnt_next;
  logic [CNT_W-1:0]          wr_level_next;
  logic                      wr_acc;
  logic                      rd_acc;
  logic [WR_DATA_WIDTH-1:0]  ram_q;
  logic [RD_DATA_WIDTH-1:0]  slices [SLICES];

  // Acceptance, next read pointer and next occupancy
  always_comb begin
    wr_acc      = wr_en & ~wr_full;
    rd_acc      = rd_en & ~rd_empty;
    rd_ptr_next = rd_ptr;
    if (rd_acc) begin
      rd_ptr_next = rd_ptr + RD_DEPTH_WIDTH'(1);
    end
    cnt_next = count;
    if (wr_acc) begin
      cnt_next = cnt_next + INC;
    end
    if (rd_acc) begin
      cnt_next = cnt_next - ONE;
    end
    wr_level_next = ceil_words(cnt_next);
  end

  // The RAM is addressed with the next read word so its output always
  // holds the word the current read pointer sits in.
  frame_fifo_ram #(
    .ADDR_W (WR_DEPTH_WIDTH),
    .DATA_W (WR_DATA_WIDTH)
  ) u_ram (
    .clk   (wr_clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr_next[RD_DEPTH_WIDTH-1:SLICE_W]),
    .q     (ram_q)
  );

  // Split the current RAM word into read-width slices, slice 0 = LSBs
  always_comb begin
    for (int k = 0; k < SLICES; k++) begin
      slices[k] = ram_q[k*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end
  end

  // Pointers, occupancy, read data and flags
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_data      <= '0;
      wr_full      <= 1'b0;
      almost_full  <= 1'b0;
      rd_empty     <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + WR_DEPTH_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_data <= slices[rd_ptr[SLICE_W-1:0]];
      end
      rd_ptr       <= rd_ptr_next;
      count        <= cnt_next;
      wr_full      <= (cnt_next > FULL_THR);
      almost_full  <= (wr_level_next >= AF_LVL);
      rd_empty     <= (cnt_next == '0);
      almost_empty <= (cnt_next <= AE_LVL);
    end
  end

`ifdef FIFO_WATER_LEVEL_EN
  // Registered fill levels in write words and read words
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_water_level <= '0;
      rd_water_level <= '0;
    end else begin
      wr_water_level <= wr_level_next[WR_DEPTH_WIDTH:0];
      rd_water_level <= cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_frame_fifo_w2n.sv
// Bench for frame_fifo_w2n: a queue of 16-bit slices models the FIFO,
// a negedge process compares every flag and rd_data against it, and a few
// literal expectations pin the model at the interesting boundaries.
module tb_frame_fifo_w2n;

  logic         wr_clk = 1'b0;
  logic         wr_rst = 1'b1;
  logic [127:0] wr_data = '0;
  logic         wr_en = 1'b0;
  logic         wr_full;
  logic         almost_full;
  logic         rd_en = 1'b0;
  logic [15:0]  rd_data;
  logic         rd_empty;
  logic         almost_empty;

  frame_fifo_w2n dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_full      (wr_full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .almost_empty (almost_empty)
  );

  always #5 wr_clk = ~wr_clk;

  logic [15:0]  mq [$];
  logic [15:0]  exp_rd = '0;
  logic         chk_en = 1'b0;
  int           n_assert = 0;
  int           n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: drive inputs, apply the FIFO rules to the model at the edge
  task automatic step(input logic we, input logic [127:0] wd, input logic re);
    int sz;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge wr_clk);
    sz = mq.size();
    if (re && sz != 0) exp_rd = mq.pop_front();
    if (we && sz <= 8184) begin
      for (int k = 0; k < 8; k++) mq.push_back(wd[16*k +: 16]);
    end
    @(negedge wr_clk);
  endtask

  // Per-cycle comparison against the model
  always @(negedge wr_clk) begin
    if (chk_en) begin
      int sz;
      sz = mq.size();
      check("wr_full",      32'(wr_full),      32'(sz > 8184));
      check("almost_full",  32'(almost_full),  32'(((sz + 7) / 8) >= 960));
      check("rd_empty",     32'(rd_empty),     32'(sz == 0));
      check("almost_empty", 32'(almost_empty), 32'(sz <= 512));
      check("rd_data",      32'(rd_data),      32'(exp_rd));
    end
  end

  initial begin
    logic [127:0] w;
    logic [127:0] last_w;
    int guard;

    // Reset and idle
    repeat (3) @(posedge wr_clk);
    @(negedge wr_clk);
    wr_rst = 1'b0;
    check("idle_rd_empty", 32'(rd_empty), 32'd1);
    check("idle_almost_empty", 32'(almost_empty), 32'd1);
    check("idle_wr_full", 32'(wr_full), 32'd0);
    check("idle_almost_full", 32'(almost_full), 32'd0);
    check("idle_rd_data", 32'(rd_data), 32'd0);
    chk_en = 1'b1;

    // Single word with slice k = k, read back in slice order
    for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(k);
    step(1'b1, w, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b1);
      check("slice_order", 32'(rd_data), k);
    end
    check("empty_after_8", 32'(rd_empty), 32'd1);

    // Fill with 1024 words
    last_w = '0;
    for (int i = 1; i <= 1024; i++) begin
      last_w = rand_word();
      step(1'b1, last_w, 1'b0);
      if (i == 959)  check("af_before_960", 32'(almost_full), 32'd0);
      if (i == 960)  check("af_at_960", 32'(almost_full), 32'd1);
      if (i == 1023) check("full_before_1024", 32'(wr_full), 32'd0);
    end
    check("full_at_1024", 32'(wr_full), 32'd1);
    check("model_full_count", mq.size(), 32'd8192);
    step(1'b1, rand_word(), 1'b0);
    check("overflow_ignored", mq.size(), 32'd8192);
    check("full_after_overflow", 32'(wr_full), 32'd1);

    // Drain everything
    for (int i = 1; i <= 8192; i++) begin
      step(1'b0, '0, 1'b1);
      if (i == 7679) check("ae_at_513", 32'(almost_empty), 32'd0);
      if (i == 7680) check("ae_at_512", 32'(almost_empty), 32'd1);
      if (i == 8191) check("not_empty_at_1", 32'(rd_empty), 32'd0);
    end
    check("empty_after_drain", 32'(rd_empty), 32'd1);
    check("last_slice", 32'(rd_data), 32'(last_w[127:112]));
    step(1'b0, '0, 1'b1);
    check("underflow_holds", 32'(rd_data), 32'(last_w[127:112]));

    // Half full, then simultaneous write and read
    for (int i = 0; i < 512; i++) step(1'b1, rand_word(), 1'b0);
    check("half_count", mq.size(), 32'd4096);
    step(1'b1, rand_word(), 1'b1);
    check("simul_plus7", mq.size(), 32'd4103);

    // Random traffic across pointer wrap
    for (int i = 0; i < 1500; i++)
      step(($urandom % 16) < 3, rand_word(), ($urandom % 2) == 0);
    for (int i = 0; i < 1500; i++)
      step(($urandom % 16) == 0, rand_word(), ($urandom % 8) != 0);
    guard = 0;
    while (mq.size() > 0 && guard < 20000) begin
      step(1'b0, '0, 1'b1);
      guard++;
    end
    check("random_drained", 32'(rd_empty), 32'd1);

    // Asynchronous reset in the middle of a burst
    step(1'b1, rand_word(), 1'b0);
    step(1'b1, rand_word(), 1'b1);
    step(1'b0, '0, 1'b1);
    #2;
    chk_en = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    wr_rst = 1'b1;
    mq.delete();
    exp_rd = '0;
    #1;
    check("arst_rd_empty", 32'(rd_empty), 32'd1);
    check("arst_almost_empty", 32'(almost_empty), 32'd1);
    check("arst_wr_full", 32'(wr_full), 32'd0);
    check("arst_almost_full", 32'(almost_full), 32'd0);
    check("arst_rd_data", 32'(rd_data), 32'd0);
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    wr_rst = 1'b0;
    chk_en = 1'b1;

    // Post-reset write/read of A5A5 pattern
    step(1'b1, {8{16'hA5A5}}, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b1);
      check("a5_slice", 32'(rd_data), 32'h0000_A5A5);
    end
    check("a5_empty", 32'(rd_empty), 32'd1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
